// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if
// Bus bundle for the multi-port register file with busy scoreboard.
//
// Parameters:
//   DATA_W  register width in bits
//   DEPTH   number of registers (power of two); ADDR_W is derived from it
//
// Signals:
//   WRITE_ENABLE0/WRITE_ADDRESS0/WRITE_DATA0  write port 0 (ALU writeback)
//   WRITE_ENABLE1/WRITE_ADDRESS1/WRITE_DATA1  write port 1 (load writeback,
//                                             wins on an address clash)
//   DATA1_ADDRESS/DATA1, DATA2_ADDRESS/DATA2  combinational read ports
//   BUSY_SET/BUSY_ADDRESS                     issue marks a destination busy
//   DATA1_BUSY/DATA2_BUSY                     busy bit of each read address
//   BUSY_COUNT                                registered number of busy regs
//
// Modports:
//   master  issue/writeback side (drives requests, receives read data)
//   slave   the register file itself
// ---------------------------------------------------------------------------
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              WRITE_ENABLE0;
  logic [ADDR_W-1:0] WRITE_ADDRESS0;
  logic [DATA_W-1:0] WRITE_DATA0;
  logic              WRITE_ENABLE1;
  logic [ADDR_W-1:0] WRITE_ADDRESS1;
  logic [DATA_W-1:0] WRITE_DATA1;
  logic [ADDR_W-1:0] DATA1_ADDRESS;
  logic [ADDR_W-1:0] DATA2_ADDRESS;
  logic [DATA_W-1:0] DATA1;
  logic [DATA_W-1:0] DATA2;
  logic              BUSY_SET;
  logic [ADDR_W-1:0] BUSY_ADDRESS;
  logic              DATA1_BUSY;
  logic              DATA2_BUSY;
  logic [ADDR_W:0]   BUSY_COUNT;

  modport master (
    output WRITE_ENABLE0, WRITE_ADDRESS0, WRITE_DATA0,
    output WRITE_ENABLE1, WRITE_ADDRESS1, WRITE_DATA1,
    output DATA1_ADDRESS, DATA2_ADDRESS,
    output BUSY_SET, BUSY_ADDRESS,
    input  DATA1, DATA2, DATA1_BUSY, DATA2_BUSY, BUSY_COUNT
  );

  modport slave (
    input  WRITE_ENABLE0, WRITE_ADDRESS0, WRITE_DATA0,
    input  WRITE_ENABLE1, WRITE_ADDRESS1, WRITE_DATA1,
    input  DATA1_ADDRESS, DATA2_ADDRESS,
    input  BUSY_SET, BUSY_ADDRESS,
    output DATA1, DATA2, DATA1_BUSY, DATA2_BUSY, BUSY_COUNT
  );
endinterface

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// DATA_W x DEPTH register file with two combinational read ports, two write
// ports and a per-register busy scoreboard used by issue logic to stall
// dependent instructions until their producer writes back.
//
// Parameters:
//   DATA_W    register width (default 32)
//   DEPTH     register count, power of two >= 2 (default 32)
//   ZERO_REG  1 = register 0 reads zero, ignores writes and busy-set
//
// Ports:
//   CLK   clock, all state updates on the rising edge
//   RST   synchronous active-high reset, overrides writes and busy-set
//   bus   reg_file_mp_if.slave (write ports, read ports, scoreboard)
//
// Build option:
//   REG_FILE_MP_BYPASS_EN  when defined, a read whose address matches an
//                          enabled write in the same cycle returns the write
//                          data (port 1 preferred) and reads not-busy unless
//                          BUSY_SET targets the same register.
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input logic          CLK,
  input logic          RST,
  reg_file_mp_if.slave bus
);
  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam bit                ZERO_EN   = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  // Population count of the busy vector; result width covers 0..DEPTH.
  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // One-hot decode of a register address.
  function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [DEPTH-1:0] one;
    one = {{(DEPTH-1){1'b0}}, 1'b1};
    return one << a;
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [ADDR_W:0]   busy_count_r;

  logic              wr0_ok_s;
  logic              wr1_ok_s;
  logic              wr0_store_s;
  logic              set_ok_s;
  logic [DEPTH-1:0]  clr_mask_s;
  logic [DEPTH-1:0]  set_mask_s;
  logic [DEPTH-1:0]  busy_next_s;
  logic [ADDR_W-1:0] rd_addr_s [2];
  logic [DATA_W-1:0] rd_data_s [2];
  logic              rd_busy_s [2];

  // Register 0 is filtered out of writes and busy-set when hardwired.
  assign wr0_ok_s = bus.WRITE_ENABLE0 &&
                    !(ZERO_EN && (bus.WRITE_ADDRESS0 == ADDR_ZERO));
  assign wr1_ok_s = bus.WRITE_ENABLE1 &&
                    !(ZERO_EN && (bus.WRITE_ADDRESS1 == ADDR_ZERO));
  assign set_ok_s = bus.BUSY_SET &&
                    !(ZERO_EN && (bus.BUSY_ADDRESS == ADDR_ZERO));

  // Port 0 loses an address clash with port 1.
  assign wr0_store_s = wr0_ok_s &&
                       !(wr1_ok_s && (bus.WRITE_ADDRESS1 == bus.WRITE_ADDRESS0));

  // Writebacks clear busy, issue sets it; set is applied last so a new
  // producer issued in the writeback cycle keeps the register busy.
  assign clr_mask_s  = (wr0_ok_s ? onehot(bus.WRITE_ADDRESS0) : {DEPTH{1'b0}}) |
                       (wr1_ok_s ? onehot(bus.WRITE_ADDRESS1) : {DEPTH{1'b0}});
  assign set_mask_s  = set_ok_s ? onehot(bus.BUSY_ADDRESS) : {DEPTH{1'b0}};
  assign busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;

  // Register storage: cleared on reset, otherwise written by both ports.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr0_store_s) begin
        mem_r[bus.WRITE_ADDRESS0] <= bus.WRITE_DATA0;
      end
      if (wr1_ok_s) begin
        mem_r[bus.WRITE_ADDRESS1] <= bus.WRITE_DATA1;
      end
    end
  end

  // Busy scoreboard and its count; the count tracks the next-state vector so
  // it lines up with the bits it describes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_r       <= {DEPTH{1'b0}};
      busy_count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_r       <= busy_next_s;
      busy_count_r <= popcount(busy_next_s);
    end
  end

  assign rd_addr_s[0] = bus.DATA1_ADDRESS;
  assign rd_addr_s[1] = bus.DATA2_ADDRESS;

  // Read mux for both ports: zero register, optional forwarding, storage.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = {DATA_W{1'b0}};
      rd_busy_s[p] = 1'b0;
      if (ZERO_EN && (rd_addr_s[p] == ADDR_ZERO)) begin
        rd_data_s[p] = {DATA_W{1'b0}};
        rd_busy_s[p] = 1'b0;
      end
`ifdef REG_FILE_MP_BYPASS_EN
      else if (wr1_ok_s && (bus.WRITE_ADDRESS1 == rd_addr_s[p])) begin
        rd_data_s[p] = bus.WRITE_DATA1;
        rd_busy_s[p] = set_ok_s && (bus.BUSY_ADDRESS == rd_addr_s[p]);
      end else if (wr0_ok_s && (bus.WRITE_ADDRESS0 == rd_addr_s[p])) begin
        rd_data_s[p] = bus.WRITE_DATA0;
        rd_busy_s[p] = set_ok_s && (bus.BUSY_ADDRESS == rd_addr_s[p]);
      end
`endif
      else begin
        rd_data_s[p] = mem_r[rd_addr_s[p]];
        rd_busy_s[p] = busy_r[rd_addr_s[p]];
      end
    end
  end

  assign bus.DATA1      = rd_data_s[0];
  assign bus.DATA2      = rd_data_s[1];
  assign bus.DATA1_BUSY = rd_busy_s[0];
  assign bus.DATA2_BUSY = rd_busy_s[1];
  assign bus.BUSY_COUNT = busy_count_r;

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor register file for the core datapath: DATA_W x DEPTH storage, two combinational read ports, two write ports and a per-register busy scoreboard.
- Write port 0 serves ALU writeback; write port 1 serves load writeback.
- Issue logic marks a destination busy and reads busy status per source operand, so dependent instructions stall until the producer writes back.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers (power of two, >= 2)
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes and busy-set ignored); 0 = register 0 is ordinary
ADDR_W, $clog2(DEPTH), derived localparam, not overridable

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
WRITE_ENABLE0  input  1  write port 0 enable
WRITE_ADDRESS0  input  ADDR_W  write port 0 address
WRITE_DATA0  input  DATA_W  write port 0 data
WRITE_ENABLE1  input  1  write port 1 enable (priority port)
WRITE_ADDRESS1  input  ADDR_W  write port 1 address
WRITE_DATA1  input  DATA_W  write port 1 data
DATA1_ADDRESS  input  ADDR_W  read port 1 address
DATA2_ADDRESS  input  ADDR_W  read port 2 address
DATA1  output  DATA_W  read port 1 data
DATA2  output  DATA_W  read port 2 data
BUSY_SET  input  1  mark BUSY_ADDRESS busy (instruction issued)
BUSY_ADDRESS  input  ADDR_W  destination register being issued
DATA1_BUSY  output  1  busy bit of DATA1_ADDRESS
DATA2_BUSY  output  1  busy bit of DATA2_ADDRESS
BUSY_COUNT  output  ADDR_W+1  number of busy registers (registered)

Behaviour:
- Clock and reset: single clock CLK; reset RST is synchronous and active-high.
- Reset: on a rising edge with RST=1, all registers, all busy bits and BUSY_COUNT are cleared to 0. RST overrides every write and busy-set in that cycle. Following reset, DATA1/DATA2=0, DATAx_BUSY=0, BUSY_COUNT=0.
- Reads: DATA1/DATA2 and DATA1_BUSY/DATA2_BUSY are combinational from the addressed entry, with zero latency. Both ports may address the same register.
- Writes: take effect on the rising edge; visible on reads the next cycle (see optional feature for same-cycle behaviour).
- Same-address dual write: WRITE_ENABLE0 and WRITE_ENABLE1 both set with equal addresses → port 1 data stored, port 0 dropped. Different addresses → both stored.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - DATA reads of address 0 return 0.
  - BUSY_SET to address 0 is ignored; busy bit 0 is constant 0.
- Scoreboard:
  - BUSY_SET=1 sets busy[BUSY_ADDRESS] at the edge.
  - Any enabled write (either port) clears busy[WRITE_ADDRESSx] at the edge.
  - BUSY_SET and a write to the same address in the same cycle → busy ends set (new producer wins).
  - BUSY_SET to an already-busy register → stays busy, no error.
  - A write to a non-busy register is legal and leaves busy at 0.
- BUSY_COUNT: registered population count of busy bits, updated every cycle from the next-state busy vector. It equals the count of set bits in the same cycle the bits become visible. Its maximum is DEPTH, or DEPTH-1 with ZERO_REG=1.

Optional Feature:
REG_FILE_MP_BYPASS_EN
- Defined: write-to-read forwarding. If a read address matches an enabled write address in the same cycle, DATAx returns that write data combinationally. If both write ports match, port 1 data is returned. DATAx_BUSY for that address reads 0 unless BUSY_SET targets the same address. Address 0 with ZERO_REG=1 still returns 0 and is never bypassed.
- Undefined: reads return stored contents only; a written value is visible one cycle after the write edge.

Test Plan:
1. RST=1 for 2 cycles after random writes, then read all addresses → every DATA=0, every busy=0, BUSY_COUNT=0.
2. Write port0 reg5=32'hDEADBEEF; next cycle DATA1_ADDRESS=5, DATA2_ADDRESS=5 → both read 32'hDEADBEEF. Write reg0=32'h1234 (ZERO_REG=1) → reg0 reads 0.
3. Same cycle: port0 reg7=32'hAAAA_AAAA, port1 reg7=32'h5555_5555 → reg7 reads 32'h5555_5555 next cycle. Repeat with bypass enabled and DATA1_ADDRESS=7 → same-cycle DATA1=32'h5555_5555; bypass disabled → DATA1 shows the old value.
4. BUSY_SET reg3, then reg9 → DATA1_BUSY(3)=1, BUSY_COUNT=2. Write port1 reg3 → busy(3)=0, BUSY_COUNT=1. BUSY_SET reg9 plus port0 write reg9 in one cycle → busy(9) stays 1.
5. Assert RST in the same cycle as a write of 32'hFFFF_FFFF to reg4 and BUSY_SET reg4 → reg4 reads 0 and busy(4)=0 afterwards.
6. Parameter sweep DATA_W=64, DEPTH=16, ZERO_REG=0: write reg0=64'h0123_4567_89AB_CDEF → it reads back; BUSY_SET of all 16 regs → BUSY_COUNT=16.
